// File: rtl/pwm_array.sv
// Multi-channel PWM generator: per-channel double-buffered {mode,duty,period},
// edge- or center-aligned counting, global in-phase resync.
module pwm_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [SEL_W-1:0]      ch_sel,
  input  logic [2*WIDTH:0]      data,
  input  logic                  resync,
  output logic [CHANNELS-1:0]   signal,
  output logic [CHANNELS-1:0]   cycle_start
);

  localparam int CFG_W = 2 * WIDTH + 1;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [CFG_W-1:0] shadow_reg, shadow_next;
      logic [CFG_W-1:0] active_reg, active_next;
      logic [WIDTH-1:0] cnt_reg, cnt_next;
      logic             dir_reg, dir_next;
      logic             restart_reg;
      logic             signal_reg;
      logic             cycle_start_reg;

      logic             mode;
      logic [WIDTH-1:0] duty;
      logic [WIDTH-1:0] period;
      logic             hit;
      logic             wrap;

      assign {mode, duty, period} = active_reg;

      always_comb begin
        hit         = load && (ch_sel == SEL_W'(gi));
        wrap        = mode ? ((dir_reg && (cnt_reg == '0)) || (period == '0))
                           : (cnt_reg == period);
        shadow_next = hit ? data : shadow_reg;
        active_next = active_reg;
        cnt_next    = cnt_reg;
        dir_next    = dir_reg;
        if (resync) begin
          active_next = shadow_reg;
          cnt_next    = '0;
          dir_next    = 1'b0;
        end else if (wrap) begin
          // A write landing on the wrap edge bypasses the shadow.
          active_next = shadow_next;
          cnt_next    = '0;
          dir_next    = 1'b0;
        end else if (!mode) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (dir_reg) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (cnt_reg == period - 1'b1) begin
          // Peak: hold the count one extra clock while turning around.
          dir_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge sys_clk) begin
        if (reset) begin
          shadow_reg      <= '0;
          active_reg      <= '0;
          cnt_reg         <= '0;
          dir_reg         <= 1'b0;
          restart_reg     <= 1'b0;
          signal_reg      <= 1'b0;
          cycle_start_reg <= 1'b0;
        end else begin
          shadow_reg      <= shadow_next;
          active_reg      <= active_next;
          cnt_reg         <= cnt_next;
          dir_reg         <= dir_next;
          restart_reg     <= resync || wrap;
          signal_reg      <= (cnt_reg < duty);
          // Delayed one extra clock so it lines up with signal for phase 0.
          cycle_start_reg <= restart_reg;
        end
      end

      assign signal[gi]      = signal_reg;
      assign cycle_start[gi] = cycle_start_reg;
    end
  endgenerate

endmodule

// File: doc/pwm_array.md
# pwm_array

Parametrised multi-channel PWM generator; successor to the single-channel 8-bit PWM driver. It provides CHANNELS independent outputs with WIDTH-bit duty and period, and a per-channel edge- or center-aligned mode. Each channel double-buffers its settings so an update applies only at that channel's cycle boundary. A global resync restarts all counters in phase. It sits on the peripheral bus next to the existing PWM driver and drives motor/LED pins directly.

## Interface
- WIDTH, 8: duty/period/counter width, ≥2
- CHANNELS, 4: number of PWM outputs, 1..16
- SEL_W, $clog2(CHANNELS) (min 1): width of ch_sel
- sys_clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- load  in  1  write strobe for the channel addressed by ch_sel
- ch_sel  in  SEL_W  target channel; ch_sel ≥ CHANNELS ignores the write
- data  in  2*WIDTH+1  {mode, duty[WIDTH-1:0], period[WIDTH-1:0]}; mode 0 = edge, 1 = center
- resync  in  1  restart all channel counters at phase 0
- signal  out  CHANNELS  PWM outputs, registered
- cycle_start  out  CHANNELS  one-clock pulse per channel when its counter restarts at phase 0

## Operation
- Per channel: shadow {mode,duty,period}, active {mode,duty,period}, counter cnt[WIDTH-1:0], direction bit dir (0 = up).
- load && ch_sel==k: shadow[k] <= data at that edge. Active registers are never written directly by load.
- Wrap (phase end) for channel k:
  - Edge mode: cnt==period.
  - Center mode: dir==1 && cnt==0, or period==0.
- At a wrap edge: active <= shadow. If a load to k coincides with the wrap, the new data goes straight to active. Then cnt <= 0, dir <= 0.
- Edge mode: cnt counts 0..P and wraps. Cycle = P+1 clocks. High clocks = min(duty, P+1).
- Center mode: cnt counts up 0..P-1, holds P-1 for one more clock while dir flips to 1, then counts down P-1..0. Cycle = 2P clocks, or 1 clock when P==0. High clocks = 2*min(duty,P), contiguous across the wrap.
- Compare is the same in both modes: raw = (cnt < duty), unsigned, full WIDTH. duty==0 gives always low. duty > cnt max gives always high.
- resync (when not in reset): every channel loads active <= shadow, cnt <= 0, dir <= 0, as if every channel wrapped this edge. resync has priority over normal counting.
- Reset: shadow, active, cnt and dir all 0 (period 0, edge mode, duty 0). signal=0 and cycle_start=0.

## Timing
- signal[k] at the edge after cycle t equals raw(t). This is 1-clock latency from the counter and is glitch-free.
- cycle_start[k] asserts in the clock after the edge on which cnt became 0 by wrap or resync, aligned with signal for phase 0.
- With period 0 in edge mode, every edge is a wrap. A load to an idle channel therefore reaches active in the same edge, and signal reflects it 1 clock later.
- A load mid-cycle has no effect on signal until the first wrap after the write. A second load before that wrap overwrites the shadow, so the last write wins.
- Reset asserted mid-cycle: at the next edge all state clears and signal=0, and it stays 0 until at least 1 clock after reset deasserts.
- Reset has priority over resync, and resync over load-to-active. A load during reset is discarded.
- Counters never exceed the active period. If active period changes at a wrap, counting restarts from 0 under the new value.

## Test plan
- Reset: hold reset 5 clocks with load=1 and data non-zero. Required: signal=0 and cycle_start=0 throughout and 1 clock after release, and no channel toggles until a load follows.
- Edge duty: WIDTH=8, ch0 duty=64, period=255. Required: a 256-clock cycle, signal[0] high for exactly 64 clocks, cycle_start[0] every 256 clocks. Also ch1 duty=0 stays always low, and ch2 duty=255 with period=127 stays always high.
- Double buffer: ch0 running duty 64 / period 255; at cnt=100 load duty=192. Required: the current cycle stays 64-high, the next cycle is 192-high, and the change lands exactly at cycle_start[0].
- Center mode: ch3 mode=1, period=4, duty=2. Required: 8-clock cycle, cnt sequence 0 1 2 3 3 2 1 0, signal high 4 contiguous clocks straddling cycle_start; duty=4 gives always high.
- Resync: channels with periods 10, 17 and 255 free-running; pulse resync for 1 clock. Required: all cycle_start bits pulse together in the next clock, and pending shadows apply at that point.
- Out-of-range select: CHANNELS=3, load with ch_sel=3. Required: no channel's settings change.
